// File: rtl/camac_pkg.sv
// camac_pkg: shared encodings for the CAMAC cycle sequencer.
//   op_t     - command operation (NAF dataway cycle, Z initialise, C clear)
//   mode_t   - repeat mode (single, Q-stop, Q-repeat)
//   state_t  - sequencer state encoding
//   fclass_t - function-code class derived from F[4:3]
//   T_*_DEF  - default phase lengths in clk cycles
package camac_pkg;

  typedef enum logic [1:0] {
    OP_NAF = 2'd0,
    OP_Z   = 2'd1,
    OP_C   = 2'd2,
    OP_BAD = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    MODE_SINGLE  = 2'd0,
    MODE_QSTOP   = 2'd1,
    MODE_QREPEAT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_S1    = 3'd2,
    ST_GAP   = 3'd3,
    ST_S2    = 3'd4,
    ST_HOLD  = 3'd5,
    ST_RESP  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    FC_READ  = 2'd0,
    FC_WRITE = 2'd1,
    FC_CTRL  = 2'd2
  } fclass_t;

  localparam int T_SETUP_DEF = 10;
  localparam int T_S1_DEF    = 10;
  localparam int T_GAP_DEF   = 10;
  localparam int T_S2_DEF    = 10;
  localparam int T_HOLD_DEF  = 10;

  // Phase timer width; every T_* must fit in it.
  localparam int TMR_W = 16;

  // F0-F7 read, F16-F23 write, everything else control.
  function automatic fclass_t f_class(input logic [4:0] f);
    case (f[4:3])
      2'b00:   return FC_READ;
      2'b10:   return FC_WRITE;
      default: return FC_CTRL;
    endcase
  endfunction

endpackage

// File: rtl/camac_phase_timer.sv
// camac_phase_timer: loadable down-counter timing each sequencer phase.
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val (takes effect on this edge)
//   load_val  - phase length in cycles (>= 1)
//   done      - high during the last cycle of the loaded phase
module camac_phase_timer
  import camac_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Loaded with N on phase entry, so cnt==1 marks the Nth (last) cycle.
  assign done = (cnt == W'(1));

endmodule

// File: rtl/camac_cycle_sequencer.sv
// camac_cycle_sequencer: runs CAMAC dataway cycles (N/A/F, S1, S2, B, Z, C)
// from a command handshake and returns one response per reported beat.
//   clk, rst                  - clock, synchronous active-high reset
//   cmd_valid/cmd_ready       - command handshake (ready only in IDLE)
//   cmd_op/mode/n/a/f/wdata/count - command fields, latched on accept
//   rsp_valid/rsp_ready       - response handshake
//   rsp_rdata/x/q/last/err/done_cnt - response fields, stable while valid
//   camac_n/a/f/w             - dataway address, function, write data
//   camac_r/x/q               - dataway read data and X/Q responses
//   camac_s1/s2/b/z/c         - strobes, busy, initialise, clear
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// SETUP | N/A/F (and W) settling before S1, B high
// S1    | first strobe (NAF only); X/Q/R sampled on last cycle
// GAP   | S1 fall to S2 rise
// S2    | second strobe
// HOLD  | S2 fall to cycle end; decides respond/repeat
// RESP  | rsp_valid=1, waiting for rsp_ready
module camac_cycle_sequencer
  import camac_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_S1    = T_S1_DEF,
  parameter int T_GAP   = T_GAP_DEF,
  parameter int T_S2    = T_S2_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int DATA_W  = 24,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_mode,
  input  logic [5:0]        cmd_n,
  input  logic [3:0]        cmd_a,
  input  logic [4:0]        cmd_f,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_x,
  output logic              rsp_q,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  rsp_done_cnt,
  output logic [5:0]        camac_n,
  output logic [3:0]        camac_a,
  output logic [4:0]        camac_f,
  output logic [DATA_W-1:0] camac_w,
  input  logic [DATA_W-1:0] camac_r,
  input  logic              camac_x,
  input  logic              camac_q,
  output logic              camac_s1,
  output logic              camac_s2,
  output logic              camac_b,
  output logic              camac_z,
  output logic              camac_c
);

  state_t              state, state_nxt;
  op_t                 op_r, op_nxt, cmd_op_t;
  mode_t               mode_r;
  logic [5:0]          n_r, n_nxt;
  logic [3:0]          a_r, a_nxt;
  logic [4:0]          f_r, f_nxt;
  logic [DATA_W-1:0]   w_r, w_nxt;
  logic [CNT_W-1:0]    lim_r, done_cnt, cnt_inc;
  logic                x_s, q_s, rep_r;
  logic [DATA_W-1:0]   rd_s;
  logic                accept, busy_nxt, hit_lim;
  logic                respond, seq_last, seq_err, seq_rep;
  logic                tmr_load, tmr_done;
  logic [TMR_W-1:0]    tmr_val;

  assign cmd_op_t  = op_t'(cmd_op);
  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // Fields as they will be after this edge; outputs are registered from
  // these so N/A/F/B/Z/C are valid in the first SETUP cycle.
  assign op_nxt = accept ? cmd_op_t  : op_r;
  assign n_nxt  = accept ? cmd_n     : n_r;
  assign a_nxt  = accept ? cmd_a     : a_r;
  assign f_nxt  = accept ? cmd_f     : f_r;
  assign w_nxt  = accept ? cmd_wdata : w_r;

  // End-of-cycle decision, consumed on the last HOLD cycle.
  always_comb begin
    cnt_inc  = done_cnt + CNT_W'(1);
    hit_lim  = (cnt_inc >= lim_r);
    respond  = 1'b1;
    seq_last = 1'b1;
    seq_err  = 1'b0;
    seq_rep  = 1'b0;
    if (op_r == OP_NAF && !x_s) begin
      seq_err = 1'b1;
    end else begin
      case (mode_r)
        MODE_QSTOP: begin
          seq_last = !q_s || hit_lim;
          seq_rep  = q_s && !hit_lim;
        end
        MODE_QREPEAT: begin
          if (!q_s) begin
            if (hit_lim) begin
              seq_err = 1'b1;
            end else begin
              respond  = 1'b0;
              seq_last = 1'b0;
              seq_rep  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = (cmd_op_t == OP_BAD) ? ST_RESP : ST_SETUP;
      ST_SETUP: if (tmr_done) state_nxt = ST_S1;
      ST_S1:    if (tmr_done) state_nxt = ST_GAP;
      ST_GAP:   if (tmr_done) state_nxt = ST_S2;
      ST_S2:    if (tmr_done) state_nxt = ST_HOLD;
      ST_HOLD:  if (tmr_done) state_nxt = respond ? ST_RESP : ST_SETUP;
      ST_RESP:  if (rsp_ready) state_nxt = rep_r ? ST_SETUP : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy_nxt = state_nxt inside {ST_SETUP, ST_S1, ST_GAP, ST_S2, ST_HOLD};

  // Every state change reloads the timer; IDLE/RESP load 0 and are untimed.
  always_comb begin
    case (state_nxt)
      ST_SETUP: tmr_val = TMR_W'(T_SETUP);
      ST_S1:    tmr_val = TMR_W'(T_S1);
      ST_GAP:   tmr_val = TMR_W'(T_GAP);
      ST_S2:    tmr_val = TMR_W'(T_S2);
      ST_HOLD:  tmr_val = TMR_W'(T_HOLD);
      default:  tmr_val = '0;
    endcase
  end
  assign tmr_load = (state_nxt != state);

  camac_phase_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      op_r         <= OP_NAF;
      mode_r       <= MODE_SINGLE;
      n_r          <= '0;
      a_r          <= '0;
      f_r          <= '0;
      w_r          <= '0;
      lim_r        <= '0;
      done_cnt     <= '0;
      x_s          <= 1'b0;
      q_s          <= 1'b0;
      rd_s         <= '0;
      rep_r        <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_x        <= 1'b0;
      rsp_q        <= 1'b0;
      rsp_last     <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_done_cnt <= '0;
      camac_n      <= '0;
      camac_a      <= '0;
      camac_f      <= '0;
      camac_w      <= '0;
      camac_s1     <= 1'b0;
      camac_s2     <= 1'b0;
      camac_b      <= 1'b0;
      camac_z      <= 1'b0;
      camac_c      <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        op_r     <= cmd_op_t;
        mode_r   <= (cmd_mode == 2'd3) ? MODE_SINGLE : mode_t'(cmd_mode);
        n_r      <= cmd_n;
        a_r      <= cmd_a;
        f_r      <= cmd_f;
        w_r      <= cmd_wdata;
        lim_r    <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
        done_cnt <= '0;
        if (cmd_op_t == OP_BAD) begin
          rep_r        <= 1'b0;
          rsp_valid    <= 1'b1;
          rsp_rdata    <= '0;
          rsp_x        <= 1'b0;
          rsp_q        <= 1'b0;
          rsp_last     <= 1'b1;
          rsp_err      <= 1'b1;
          rsp_done_cnt <= '0;
        end
      end

      if (state == ST_S1 && tmr_done) begin
        x_s  <= camac_x;
        q_s  <= camac_q;
        rd_s <= (f_class(f_r) == FC_READ) ? camac_r : '0;
      end

      if (state == ST_HOLD && tmr_done) begin
        done_cnt <= cnt_inc;
        if (respond) begin
          rep_r        <= seq_rep;
          rsp_valid    <= 1'b1;
          rsp_rdata    <= rd_s;
          rsp_x        <= x_s;
          rsp_q        <= q_s;
          rsp_last     <= seq_last;
          rsp_err      <= seq_err;
          rsp_done_cnt <= cnt_inc;
        end
      end

      if (state == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      camac_b  <= busy_nxt;
      camac_s1 <= (state_nxt == ST_S1) && (op_nxt == OP_NAF);
      camac_s2 <= (state_nxt == ST_S2);
      camac_z  <= busy_nxt && (op_nxt == OP_Z);
      camac_c  <= busy_nxt && (op_nxt == OP_C);
      camac_n  <= (busy_nxt && op_nxt == OP_NAF) ? n_nxt : '0;
      camac_a  <= (busy_nxt && op_nxt == OP_NAF) ? a_nxt : '0;
      camac_f  <= (busy_nxt && op_nxt == OP_NAF) ? f_nxt : '0;
      camac_w  <= (busy_nxt && op_nxt == OP_NAF && f_class(f_nxt) == FC_WRITE) ? w_nxt : '0;
    end
  end

endmodule

// File: tb/tb_camac_cycle_sequencer.sv
module tb_camac_cycle_sequencer;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_mode;
  logic [5:0]  cmd_n;
  logic [3:0]  cmd_a;
  logic [4:0]  cmd_f;
  logic [23:0] cmd_wdata;
  logic [15:0] cmd_count;
  logic        rsp_valid, rsp_ready;
  logic [23:0] rsp_rdata;
  logic        rsp_x, rsp_q, rsp_last, rsp_err;
  logic [15:0] rsp_done_cnt;
  logic [5:0]  camac_n;
  logic [3:0]  camac_a;
  logic [4:0]  camac_f;
  logic [23:0] camac_w, camac_r;
  logic        camac_x, camac_q;
  logic        camac_s1, camac_s2, camac_b, camac_z, camac_c;

  camac_cycle_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_n(cmd_n), .cmd_a(cmd_a),
    .cmd_f(cmd_f), .cmd_wdata(cmd_wdata), .cmd_count(cmd_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_x(rsp_x), .rsp_q(rsp_q), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .rsp_done_cnt(rsp_done_cnt),
    .camac_n(camac_n), .camac_a(camac_a), .camac_f(camac_f),
    .camac_w(camac_w), .camac_r(camac_r), .camac_x(camac_x), .camac_q(camac_q),
    .camac_s1(camac_s1), .camac_s2(camac_s2), .camac_b(camac_b),
    .camac_z(camac_z), .camac_c(camac_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard of expected responses.
  typedef struct {
    logic [23:0] rdata;
    logic        x, q, last, err;
    logic [15:0] dc;
    logic        chk_xqd;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      check("rsp_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_xqd) begin
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_x", rsp_x, e.x);
          check("rsp_q", rsp_q, e.q);
        end
        check("rsp_last", rsp_last, e.last);
        check("rsp_err", rsp_err, e.err);
        check("rsp_done_cnt", rsp_done_cnt, e.dc);
      end
    end
  end

  // Dataway model: a new Q value is presented at each S1 rise.
  logic q_plan[$];
  logic q_default;
  logic s1_prev = 1'b0;
  always @(negedge clk) begin
    if (camac_s1 && !s1_prev)
      camac_q = (q_plan.size() > 0) ? q_plan.pop_front() : q_default;
    s1_prev = camac_s1;
  end

  function automatic exp_t mk(input logic [23:0] rd, input logic x, input logic q,
                              input logic last, input logic err, input logic [15:0] dc);
    exp_t e;
    e.rdata = rd; e.x = x; e.q = q; e.last = last; e.err = err; e.dc = dc; e.chk_xqd = 1'b1;
    return e;
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] mode, input logic [5:0] n,
                          input logic [3:0] a, input logic [4:0] f, input logic [23:0] wd,
                          input logic [15:0] cnt);
    bit got = 0;
    @(negedge clk);
    cmd_op = op; cmd_mode = mode; cmd_n = n; cmd_a = a; cmd_f = f;
    cmd_wdata = wd; cmd_count = cnt; cmd_valid = 1'b1;
    for (int i = 0; i < 500 && !got; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        got = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1 cmd_valid = 1'b0;
    check("cmd_accept", got, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && (sb.size() != 0 || rsp_valid); i++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
    @(negedge clk);
    check("idle_ready", cmd_ready, 1);
  endtask

  typedef struct {
    logic [1:0]  op, mode;
    logic [5:0]  n;
    logic [3:0]  a;
    logic [4:0]  f;
    logic [23:0] wdata, r;
    logic        x, q;
    logic [15:0] cnt;
    logic [23:0] e_rdata;
    logic        e_err;
    logic [23:0] e_w;
    logic        e_b;
  } vec_t;
  vec_t vt[8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1c, s2c, zc, cc, nz, stall_ok;
    exp_t e;
    //        op mode  n      a     f      wdata        r           x  q  cnt e_rdata      err e_w          b
    vt[0] = '{2'd0, 2'd0, 6'd5,  4'd2, 5'd0,  24'h000777, 24'hABCDEF, 1, 1, 0, 24'hABCDEF, 0, 24'h000000, 1};
    vt[1] = '{2'd0, 2'd0, 6'd3,  4'd1, 5'd16, 24'h123456, 24'h55AA55, 1, 1, 0, 24'h000000, 0, 24'h123456, 1};
    vt[2] = '{2'd0, 2'd0, 6'd1,  4'd0, 5'd8,  24'h0000AA, 24'hFFFFFF, 1, 0, 0, 24'h000000, 0, 24'h000000, 1};
    vt[3] = '{2'd0, 2'd0, 6'd63, 4'd15,5'd23, 24'h0F0F0F, 24'h111111, 1, 1, 0, 24'h000000, 0, 24'h0F0F0F, 1};
    vt[4] = '{2'd0, 2'd0, 6'd9,  4'd3, 5'd7,  24'h000000, 24'h000001, 0, 1, 0, 24'h000001, 1, 24'h000000, 1};
    vt[5] = '{2'd3, 2'd0, 6'd4,  4'd4, 5'd0,  24'hFFFFFF, 24'h222222, 1, 1, 0, 24'h000000, 1, 24'h000000, 0};
    vt[6] = '{2'd0, 2'd3, 6'd2,  4'd5, 5'd24, 24'h333333, 24'h444444, 1, 0, 0, 24'h000000, 0, 24'h000000, 1};
    vt[7] = '{2'd0, 2'd1, 6'd12, 4'd7, 5'd1,  24'h000000, 24'h00BEEF, 1, 1, 0, 24'h00BEEF, 0, 24'h000000, 1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 0; cmd_mode = 0; cmd_n = 0; cmd_a = 0; cmd_f = 0;
    cmd_wdata = 0; cmd_count = 0; rsp_ready = 1'b1; camac_r = 0; camac_x = 1'b1;
    camac_q = 1'b1; q_default = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_rdata, rsp_x, rsp_q, rsp_last, rsp_err, rsp_done_cnt}, 0);
    check("rst_strobes", {camac_s1, camac_s2, camac_b, camac_z, camac_c}, 0);
    check("rst_dataway", {camac_n, camac_a, camac_f, camac_w}, 0);
    rst = 1'b0;
    #1 check("ready_after_rst", cmd_ready, 1);

    // Table of single-beat commands.
    for (int i = 0; i < 8; i++) begin
      camac_r = vt[i].r; camac_x = vt[i].x; q_default = vt[i].q;
      sb.push_back(mk(vt[i].e_rdata, vt[i].e_b ? vt[i].x : 1'b0, vt[i].e_b ? vt[i].q : 1'b0,
                      1'b1, vt[i].e_err, vt[i].e_b ? 16'd1 : 16'd0));
      send_cmd(vt[i].op, vt[i].mode, vt[i].n, vt[i].a, vt[i].f, vt[i].wdata, vt[i].cnt);
      repeat (5) @(negedge clk);
      check($sformatf("v%0d_b", i), camac_b, vt[i].e_b);
      check($sformatf("v%0d_n", i), camac_n, vt[i].e_b ? vt[i].n : 6'd0);
      check($sformatf("v%0d_a", i), camac_a, vt[i].e_b ? vt[i].a : 4'd0);
      check($sformatf("v%0d_f", i), camac_f, vt[i].e_b ? vt[i].f : 5'd0);
      check($sformatf("v%0d_w", i), camac_w, vt[i].e_w);
      check($sformatf("v%0d_zc", i), {camac_z, camac_c}, 0);
      wait_drain();
    end

    // Exact strobe timing relative to the accept edge.
    camac_r = 24'hABCDEF; camac_x = 1'b1; q_default = 1'b1;
    sb.push_back(mk(24'hABCDEF, 1, 1, 1, 0, 16'd1));
    send_cmd(2'd0, 2'd0, 6'd5, 4'd2, 5'd0, 24'h0, 16'd0);
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      check($sformatf("tim_s1_c%0d", k), camac_s1, (k >= 11 && k <= 20));
      check($sformatf("tim_s2_c%0d", k), camac_s2, (k >= 31 && k <= 40));
      check($sformatf("tim_b_c%0d", k), camac_b, (k >= 1 && k <= 50));
      check($sformatf("tim_rv_c%0d", k), rsp_valid, (k == 51));
    end
    wait_drain();

    // QSTOP, count 4, Q = 1,1,0.
    camac_r = 24'h000042; camac_x = 1'b1; q_default = 1'b1;
    q_plan = {1'b1, 1'b1, 1'b0};
    sb.push_back(mk(24'h42, 1, 1, 0, 0, 16'd1));
    sb.push_back(mk(24'h42, 1, 1, 0, 0, 16'd2));
    sb.push_back(mk(24'h42, 1, 0, 1, 0, 16'd3));
    send_cmd(2'd0, 2'd1, 6'd5, 4'd0, 5'd0, 24'h0, 16'd4);
    wait_drain();
    check("qstop_beats_used", q_plan.size(), 0);

    // QREPEAT, count 3, Q always 0: one error response after 3 cycles.
    q_plan = {1'b0, 1'b0, 1'b0};
    sb.push_back(mk(24'h42, 1, 0, 1, 1, 16'd3));
    send_cmd(2'd0, 2'd2, 6'd5, 4'd0, 5'd0, 24'h0, 16'd3);
    wait_drain();
    check("qrep_beats_used", q_plan.size(), 0);

    // QREPEAT, count 5, Q = 0,1: one good response after 2 cycles.
    q_plan = {1'b0, 1'b1};
    sb.push_back(mk(24'h42, 1, 1, 1, 0, 16'd2));
    send_cmd(2'd0, 2'd2, 6'd5, 4'd0, 5'd0, 24'h0, 16'd5);
    wait_drain();

    // Z then C ops.
    for (int op = 1; op <= 2; op++) begin
      e = mk(0, 0, 0, 1, 0, 16'd1);
      e.chk_xqd = 1'b0;
      sb.push_back(e);
      send_cmd(op[1:0], 2'd0, 6'd7, 4'd3, 5'd16, 24'hABCDEF, 16'd0);
      s1c = 0; s2c = 0; zc = 0; cc = 0; nz = 0;
      for (int k = 1; k <= 60; k++) begin
        @(negedge clk);
        s1c += camac_s1; s2c += camac_s2; zc += camac_z; cc += camac_c;
        if (camac_n != 0 || camac_a != 0 || camac_f != 0 || camac_w != 0) nz++;
      end
      check($sformatf("op%0d_s1_cycles", op), s1c, 0);
      check($sformatf("op%0d_s2_cycles", op), s2c, 10);
      check($sformatf("op%0d_z_cycles", op), zc, (op == 1) ? 50 : 0);
      check($sformatf("op%0d_c_cycles", op), cc, (op == 2) ? 50 : 0);
      check($sformatf("op%0d_naf_nonzero", op), nz, 0);
      wait_drain();
    end

    // Reset in the middle of S1.
    camac_x = 1'b1; q_default = 1'b1;
    send_cmd(2'd0, 2'd0, 6'd1, 4'd1, 5'd0, 24'h0, 16'd0);
    for (int i = 0; i < 100 && !camac_s1; i++) @(negedge clk);
    check("rst_reach_s1", camac_s1, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_s1", camac_s1, 0);
    check("rst_mid_b", camac_b, 0);
    check("rst_mid_rv", rsp_valid, 0);
    check("rst_mid_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_mid_ready_after", cmd_ready, 1);
    camac_r = 24'h00C0DE;
    sb.push_back(mk(24'h00C0DE, 1, 1, 1, 0, 16'd1));
    send_cmd(2'd0, 2'd0, 6'd2, 4'd2, 5'd2, 24'h0, 16'd0);
    wait_drain();

    // Back-pressure: response held for 20 cycles.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    camac_r = 24'h5A5A5A;
    sb.push_back(mk(24'h5A5A5A, 1, 1, 1, 0, 16'd1));
    send_cmd(2'd0, 2'd0, 6'd3, 4'd3, 5'd3, 24'h0, 16'd0);
    for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
    check("bp_rsp_arrives", rsp_valid, 1);
    stall_ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_rdata == 24'h5A5A5A && rsp_last && !rsp_err && rsp_done_cnt == 16'd1 &&
          !camac_b && !camac_s1 && !camac_s2 && !cmd_ready)
        stall_ok++;
    end
    check("bp_stable_cycles", stall_ok, 20);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/camac_cycle_sequencer.md
CAMAC_CYCLE_SEQUENCER -- requirements
Module: camac_cycle_sequencer

Interface
REQ-001 SHALL have parameter T_SETUP, default 10, clk cycles from N/A/F valid to S1 rise.
REQ-002 SHALL have parameter T_S1, default 10, S1 strobe width in clk cycles.
REQ-003 SHALL have parameter T_GAP, default 10, clk cycles from S1 fall to S2 rise.
REQ-004 SHALL have parameter T_S2, default 10, S2 strobe width in clk cycles.
REQ-005 SHALL have parameter T_HOLD, default 10, clk cycles from S2 fall to cycle end; all T_* are at least 1.
REQ-006 SHALL have parameter DATA_W, default 24, dataway R/W width.
REQ-007 SHALL have parameter CNT_W, default 16, repeat-count width.
REQ-008 clk input 1: single clock, 50 MHz nominal; one clock for the whole block.
REQ-009 rst input 1: reset, synchronous and active-high.
REQ-010 cmd_valid/cmd_ready input/output 1: command handshake; transfer when both are high on a clk edge.
REQ-011 cmd_op input 2, cmd_mode input 2, cmd_n input 6, cmd_a input 4, cmd_f input 5, cmd_wdata input DATA_W, cmd_count input CNT_W: command fields.
REQ-012 rsp_valid/rsp_ready output/input 1: response handshake.
REQ-013 rsp_rdata output DATA_W, rsp_x output 1, rsp_q output 1, rsp_last output 1, rsp_err output 1, rsp_done_cnt output CNT_W: response fields.
REQ-014 camac_n output 6, camac_a output 4, camac_f output 5, camac_w output DATA_W, camac_r input DATA_W, camac_x input 1, camac_q input 1: dataway signals.
REQ-015 camac_s1, camac_s2, camac_b, camac_z, camac_c output 1 each: strobes, busy, initialise, clear.

Function
REQ-016 cmd_op encodings: NAF=0, Z=1, C=2; 3 is rejected with a single response having rsp_err=1 and rsp_last=1, and no dataway cycle.
REQ-017 cmd_mode encodings: SINGLE=0, QSTOP=1, QREPEAT=2; 3 is treated as SINGLE.
REQ-018 States: IDLE, SETUP, S1, GAP, S2, HOLD, RESP; each timed state lasts exactly its T_* cycles.
REQ-019 cmd_ready is high only in IDLE; command fields are latched on the transfer edge; the next cycle is SETUP.
REQ-020 In SETUP through HOLD: camac_b=1 and camac_n/a/f hold the latched values.
REQ-021 camac_w drives cmd_wdata only when F[4:3]=2'b10 (F16–F23); otherwise camac_w is 0.
REQ-022 NAF op: camac_s1=1 in S1 and camac_s2=1 in S2.
REQ-023 Z and C ops: no S1; camac_s2=1 in S2; camac_z (Z op) or camac_c (C op) is held high for SETUP through HOLD; N/A/F are driven as 0.
REQ-024 On the last clk of S1: sample camac_x and camac_q; sample camac_r into rsp_rdata when F[4:3]=2'b00, otherwise rsp_rdata=0.
REQ-025 rsp_done_cnt increments once per completed dataway cycle; it is 0 at command acceptance.
REQ-026 cmd_count=0 is treated as 1.
REQ-027 SINGLE mode: one cycle, one response, rsp_last=1.
REQ-028 QSTOP mode: one response per cycle; repeat while Q=1 and rsp_done_cnt<cmd_count; rsp_last=1 on the Q=0 beat or the count-limit beat.
REQ-029 QREPEAT mode: repeat silently while Q=0 and rsp_done_cnt<cmd_count; produce one response when Q=1 (rsp_err=0) or when the count is exhausted (rsp_err=1); that response has rsp_last=1.
REQ-030 X=0 on a NAF cycle sets rsp_err=1 and rsp_last=1 and ends the sequence in any mode.
REQ-031 RESP: rsp_valid=1 and rsp_* are stable until rsp_ready; back-pressure stalls the sequencer in RESP with all strobes low.
REQ-032 After a RESP handshake, go to SETUP if repeating, else to IDLE.
REQ-033 Response latency: RESP is entered one clk after HOLD ends, so the minimum command-to-rsp_valid time is T_SETUP+T_S1+T_GAP+T_S2+T_HOLD+1 cycles (51 with defaults).
REQ-034 Strobes, camac_z and camac_c are registered outputs with no glitches.

Reset
REQ-035 rst takes priority over everything, including mid-cycle: next state IDLE.
REQ-036 Reset values: all camac_* outputs 0, rsp_valid=0, all rsp_* fields 0, cmd_ready=0 while rst=1, and cmd_ready=1 on the first cycle after rst falls.

Structure
REQ-037 Shared package camac_pkg SHALL hold the op and mode encodings, the state encoding, the default T_* values and the F-class decode (read/write/control).
REQ-038 One sub-module camac_phase_timer SHALL be used: a loadable down-counter with a done pulse that drives all timed states.

Verification
REQ-039 SINGLE NAF N=5 A=2 F=0, camac_r=24'hABCDEF, X=Q=1 -> S1 high cycles 11–20 and S2 high cycles 31–40 after accept; rsp_rdata=ABCDEF, x=1, q=1, last=1, rsp_valid at cycle 51.
REQ-040 SINGLE F=16, wdata=24'h123456 -> camac_w=123456 for SETUP–HOLD; rsp_rdata=0.
REQ-041 QSTOP count=4, Q=1,1,0 -> 3 responses; third has last=1, done_cnt=3.
REQ-042 QREPEAT count=3, Q always 0 -> exactly one response, err=1, done_cnt=3; then repeat with Q=1 on the 2nd cycle -> one response, err=0.
REQ-043 Z op -> camac_z high for 50 cycles, S1 never high, S2 high for 10 cycles; C op -> same with camac_c.
REQ-044 rst asserted in S1 -> on the next edge S1=0, B=0, rsp_valid=0; a command accepted after reset completes normally; rsp_ready held low for 20 cycles -> rsp stable, no new cycle starts.
